// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-outstanding instruction fetch into a prefetch FIFO,
// issuing one- and two-word instructions to decode with stall and redirect.
module fetch_sequencer #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [5:0]  OPC_LONG = 6'h00
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] ins,
  output logic [15:0] ext,
  output logic        ins_en,
  output logic [15:0] pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;
  state_t state, state_nx;
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] count, count_nx, pops;
  logic [15:0] fpc, fpc_nx, ipc, head, nxt;
  logic is_long, issue, push;
  function automatic logic [AW-1:0] wrap(input logic [AW-1:0] p, input logic [CW-1:0] n);
    return AW'((32'(p) + 32'(n)) % DEPTH);
  endfunction
  // Issue only sees words already buffered; a same-cycle ack is usable next cycle.
  always_comb begin
    head     = mem[rd];
    nxt      = mem[wrap(rd, CW'(1))];
    is_long  = head[15:10] == OPC_LONG;
    push     = state == FETCH && imem_ack && !redirect;
    issue    = !stall && !redirect && (is_long ? count >= CW'(2) : count != '0);
    pops     = issue ? (is_long ? CW'(2) : CW'(1)) : '0;
    count_nx = redirect ? '0 : count + CW'(push) - pops;
    fpc_nx   = redirect ? redirect_pc : fpc + 16'(push);
  end
  always_ff @(posedge cpu_clk or negedge cpu_rst)
    if (!cpu_rst) state <= IDLE;
    else state <= state_nx;
  // A redirect over an unacked request must still wait out that request in DROP.
  always_comb begin
    state_nx = redirect ? ((imem_req && !imem_ack) ? DROP : FETCH) :
               state == IDLE  ? (count_nx < FULL ? FETCH : IDLE) :
               state == FETCH ? ((imem_ack && count_nx == FULL) ? IDLE : FETCH) :
               (imem_ack ? FETCH : DROP);
  end
  always_comb begin
    imem_req = state != IDLE;
  end
  always_ff @(posedge cpu_clk)
    if (push) mem[wr] <= imem_rdata;
  always_ff @(posedge cpu_clk or negedge cpu_rst)
    if (!cpu_rst) begin
      rd        <= '0;
      wr        <= '0;
      count     <= '0;
      fpc       <= RESET_PC;
      ipc       <= RESET_PC;
      imem_addr <= RESET_PC;
      ins       <= '0;
      ext       <= '0;
      ins_en    <= 1'b0;
      pc        <= RESET_PC;
    end else begin
      rd        <= redirect ? '0 : wrap(rd, pops);
      wr        <= redirect ? '0 : push ? wrap(wr, CW'(1)) : wr;
      count     <= count_nx;
      fpc       <= fpc_nx;
      ipc       <= redirect ? redirect_pc : ipc + 16'(pops);
      imem_addr <= state_nx == DROP ? imem_addr : fpc_nx;
      ins_en    <= issue;
      if (issue) begin
        ins <= head;
        ext <= is_long ? nxt : '0;
        pc  <= ipc;
      end
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Front-end controller that sequences instruction fetch for the decoder.
- Issues single-outstanding word reads to instruction memory and buffers the returned words in a small prefetch FIFO.
- Assembles one-word and two-word (opcode plus extension word) instructions and presents them to decode as `ins`/`ext`/`ins_en` pulses.
- Honours downstream stall and PC redirect (jump/branch taken) with buffer flush.

Parameters:
- DEPTH, 4, prefetch FIFO depth in 16-bit words; legal range 2..16.
- RESET_PC, 16'h0000, word address fetched first after reset.
- OPC_LONG, 6'h00, opcode value (ins[15:10]) of the only instruction that carries an extension word.

Ports:
- cpu_clk  in  1  clock; all state updates on rising edge.
- cpu_rst  in  1  reset; asynchronous, active-low (0 = reset).
- imem_req  out  1  read request; held until imem_ack.
- imem_addr  out  16  word address of the request; stable while imem_req=1.
- imem_ack  in  1  request accepted; imem_rdata valid this same cycle.
- imem_rdata  in  16  returned instruction word.
- stall  in  1  decode cannot accept an instruction this cycle.
- redirect  in  1  load new fetch PC; single-cycle pulse.
- redirect_pc  in  16  target word address, sampled when redirect=1.
- ins  out  16  instruction word to decode.
- ext  out  16  extension word; 16'h0000 for one-word instructions.
- ins_en  out  1  ins/ext/pc valid; one-cycle pulse per instruction.
- pc  out  16  word address of the instruction currently on ins.

Behaviour:
- Reset (cpu_rst=0, async):
  - Outputs: imem_req=0, imem_addr=RESET_PC, ins=0, ext=0, ins_en=0, pc=RESET_PC.
  - Internal: FIFO empty, fetch pointer fpc=RESET_PC, issue pointer ipc=RESET_PC, state IDLE.
  - Release mid-request is permitted; the memory side must tolerate the abandoned request.
- FSM:
  - IDLE: if FIFO count < DEPTH → FETCH with imem_req=1 and imem_addr=fpc, asserted on the next edge; otherwise stay in IDLE.
  - FETCH, on imem_ack:
    - Push imem_rdata into the FIFO and set fpc=fpc+1 (16-bit wrap, FFFF→0000).
    - If count after push and pop < DEPTH, stay in FETCH and present the new address the next cycle; else go to IDLE.
  - DROP: entered when redirect arrives while imem_req=1 and no imem_ack in that cycle.
    - imem_req/imem_addr stay unchanged until imem_ack; the acked data is discarded.
    - Then go to FETCH with imem_addr=fpc, which was already loaded with redirect_pc.
  - imem_req never drops, and imem_addr never changes, while a request is unacked.
- Issue (registered outputs; one instruction per cycle maximum):
  - Condition: stall=0, no redirect this cycle, and the FIFO head is present.
  - Short instruction (head[15:10] != OPC_LONG): needs count ≥ 1. Pop 1; ins=head, ext=0, pc=ipc, ins_en=1; ipc += 1.
  - Long instruction: needs count ≥ 2. Pop 2; ins=head, ext=next word, pc=ipc, ins_en=1; ipc += 2.
  - A long instruction with only its first word buffered waits; no partial issue.
  - Otherwise ins_en=0, and ins/ext/pc hold their last values.
- FIFO count is computed from words already buffered; a same-cycle push (imem_ack) is not usable for issue until the next cycle.
- Simultaneous push and pop in one cycle is legal; count changes by pushes minus pops.
- Redirect (highest priority):
  - Flush the FIFO and suppress ins_en this cycle; fpc=ipc=redirect_pc.
  - An imem_ack arriving in the same cycle as redirect is discarded.
  - If no request is pending: go to FETCH, with the first request to redirect_pc on the next cycle.
  - If a request is pending with no ack this cycle: go to DROP.
- Latency: on an empty FIFO with zero-wait memory (ack in the first req cycle), ins_en follows 2 cycles after imem_req rises.
- Address arithmetic is modulo 2^16 throughout.

Test Plan:
- Reset release with RESET_PC=0, memory acks every cycle, words 16'h4000/16'h4401/16'h4802 (non-long) → imem_addr 0,1,2,…; ins_en pulses with pc 0,1,2 and ins in order, ext=0.
- Long instruction 16'h0012 at address 5 followed by ext 16'hBEEF, ack delayed 3 cycles on address 6 → no ins_en until the ext arrives, then ins=0012, ext=BEEF, pc=5; next issued pc=7.
- stall held 10 cycles with DEPTH=4 → exactly 4 acks, then imem_req=0; on stall release 4 consecutive ins_en pulses and fetch resumes.
- redirect to 16'h0100 while imem_req pending on address 3, ack 2 cycles later → that data is dropped and never issued; next imem_addr=0100; first issued pc=0100.
- redirect and imem_ack in the same cycle with stall=0 and a non-empty FIFO → no ins_en that cycle, ack data discarded, FIFO empty next cycle.
- fpc at 16'hFFFF → next imem_addr=0000; asserting cpu_rst=0 mid-FETCH → imem_req=0 immediately and all outputs at reset values.
